// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipe writes win, displaced long-latency results queue in a FIFO.
// Zero-cycle combinational select; lu_ready drops while the FIFO is full, and decode stalls on pending destinations.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                         cpu_clk_50M,
  input  logic                         cpu_rst,
  input  logic                         pipe_we,
  input  logic [4:0]                   pipe_wa,
  input  logic [31:0]                  pipe_wd,
  input  logic                         lu_valid,
  input  logic [4:0]                   lu_wa,
  input  logic [31:0]                  lu_wd,
  output logic                         lu_ready,
  input  logic                         iss_valid,
  input  logic [4:0]                   iss_wa,
  input  logic [4:0]                   chk_ra1,
  input  logic [4:0]                   chk_ra2,
  input  logic [4:0]                   chk_wa,
  output logic                         stall,
  output logic                         we,
  output logic [4:0]                   wa,
  output logic [31:0]                  wd,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [4:0]    mem_wa [DEPTH];
  logic [31:0]   mem_wd [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;

  logic run;
  logic pipe_occ;
  logic fifo_empty;
  logic lu_acc_nz;
  logic pop;
  logic bypass;
  logic push;
  logic lu_write;
  logic hit1;
  logic hit2;
  logic hit3;

  always_comb begin
    run        = !cpu_rst;
    pipe_occ   = run && pipe_we && (pipe_wa != 5'd0);
    fifo_empty = (fifo_cnt == '0);
    lu_ready   = run && (fifo_cnt < CW'(DEPTH));
    lu_acc_nz  = lu_valid && lu_ready && (lu_wa != 5'd0);
    pop        = run && !pipe_occ && !fifo_empty;
    bypass     = run && !pipe_occ && fifo_empty && lu_acc_nz;
    // A new result queues behind any occupant so it never overtakes older entries.
    push       = lu_acc_nz && (pipe_occ || !fifo_empty);
    lu_write   = pop || bypass;
  end

  always_comb begin
    we = 1'b0;
    wa = 5'd0;
    wd = 32'd0;
    if (pipe_occ) begin
      we = 1'b1;
      wa = pipe_wa;
      wd = pipe_wd;
    end else if (pop) begin
      we = 1'b1;
      wa = mem_wa[rd_ptr];
      wd = mem_wd[rd_ptr];
    end else if (bypass) begin
      we = 1'b1;
      wa = lu_wa;
      wd = lu_wd;
    end
  end

  // A register being written by the long-latency path this cycle is forwarded by the regfile.
  always_comb begin
    hit1  = (chk_ra1 != 5'd0) && busy[chk_ra1] && !(lu_write && (wa == chk_ra1));
    hit2  = (chk_ra2 != 5'd0) && busy[chk_ra2] && !(lu_write && (wa == chk_ra2));
    hit3  = (chk_wa  != 5'd0) && busy[chk_wa]  && !(lu_write && (wa == chk_wa));
    stall = run && (hit1 || hit2 || hit3);
  end

  always_comb begin
    busy_nxt = busy;
    if (lu_write) busy_nxt[wa] = 1'b0;
    if (iss_valid && (iss_wa != 5'd0)) busy_nxt[iss_wa] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (push) begin
      mem_wa[wr_ptr] <= lu_wa;
      mem_wd[wr_ptr] <= lu_wd;
    end
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      busy     <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  logic        cpu_clk_50M;
  logic        cpu_rst;
  logic        pipe_we;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;
  logic        lu_valid;
  logic [4:0]  lu_wa;
  logic [31:0] lu_wd;
  logic        lu_ready;
  logic        iss_valid;
  logic [4:0]  iss_wa;
  logic [4:0]  chk_ra1;
  logic [4:0]  chk_ra2;
  logic [4:0]  chk_wa;
  logic        stall;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [$clog2(DEPTH+1)-1:0] fifo_cnt;

  int vectors;
  int miscompares;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .lu_valid(lu_valid), .lu_wa(lu_wa), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_wa(iss_wa),
    .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_wa(chk_wa),
    .stall(stall), .we(we), .wa(wa), .wd(wd), .fifo_cnt(fifo_cnt)
  );

  initial cpu_clk_50M = 1'b0;
  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic tick();
    @(posedge cpu_clk_50M);
    #2;
  endtask

  task automatic idle();
    pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
    lu_valid = 0; lu_wa = 0; lu_wd = 0;
    iss_valid = 0; iss_wa = 0;
    chk_ra1 = 0; chk_ra2 = 0; chk_wa = 0;
  endtask

  task automatic test_reset();
    idle();
    cpu_rst = 1;
    tick();
    #4;
    vectors++;
    if ({we, lu_ready, stall, fifo_cnt} !== {1'b0, 1'b0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_init: we/rdy/stall/cnt=%b%b%b/%0d want 000/0", we, lu_ready, stall, fifo_cnt);
    end
    tick();
    cpu_rst = 0;
    #4;
    vectors++;
    if (lu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 1", lu_ready);
    end
    // Build fifo_cnt=2 with busy[5]=1, then reset mid-operation.
    tick();
    iss_valid = 1; iss_wa = 5;
    pipe_we = 1; pipe_wa = 1; pipe_wd = 32'h11;
    lu_valid = 1; lu_wa = 8; lu_wd = 32'h80;
    tick();
    iss_valid = 0; iss_wa = 0;
    lu_wa = 9; lu_wd = 32'h90;
    tick();
    lu_valid = 0;
    chk_ra1 = 5;
    #4;
    vectors++;
    if ({fifo_cnt, stall} !== {2'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_precond: cnt/stall=%0d/%b want 2/1", fifo_cnt, stall);
    end
    cpu_rst = 1;
    #1;
    vectors++;
    if ({we, lu_ready, stall, fifo_cnt} !== {1'b0, 1'b0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_async: we/rdy/stall/cnt=%b%b%b/%0d want 000/0", we, lu_ready, stall, fifo_cnt);
    end
    tick();
    cpu_rst = 0;
    pipe_we = 0;
    #4;
    vectors++;
    if ({lu_ready, stall, we} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_after: rdy/stall/we=%b%b%b want 100", lu_ready, stall, we);
    end
    tick();
    idle();
  endtask

  task automatic test_bypass();
    idle();
    lu_valid = 1; lu_wa = 5; lu_wd = 32'h00001234;
    #4;
    vectors++;
    if ({we, wa, wd} !== {1'b1, 5'd5, 32'h00001234}) begin
      miscompares++;
      $display("FAIL bypass_write: we/wa/wd=%b/%0d/%h want 1/5/00001234", we, wa, wd);
    end
    tick();
    idle();
    #4;
    vectors++;
    if (fifo_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL bypass_cnt: got %0d want 0", fifo_cnt);
    end
  endtask

  task automatic test_conflict();
    idle();
    pipe_we = 1; pipe_wa = 3; pipe_wd = 32'hAAAA0000;
    lu_valid = 1; lu_wa = 7; lu_wd = 32'h0000BBBB;
    #4;
    vectors++;
    if ({we, wa, wd} !== {1'b1, 5'd3, 32'hAAAA0000}) begin
      miscompares++;
      $display("FAIL conflict_pipe: we/wa/wd=%b/%0d/%h want 1/3/AAAA0000", we, wa, wd);
    end
    tick();
    idle();
    #4;
    vectors++;
    if ({fifo_cnt, we, wa, wd} !== {2'd1, 1'b1, 5'd7, 32'h0000BBBB}) begin
      miscompares++;
      $display("FAIL conflict_drain: cnt/we/wa/wd=%0d/%b/%0d/%h want 1/1/7/0000BBBB", fifo_cnt, we, wa, wd);
    end
    tick();
    vectors++;
    if (fifo_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL conflict_cnt: got %0d want 0", fifo_cnt);
    end
  endtask

  task automatic test_full_order();
    logic [4:0] exp_wa [3];
    exp_wa[0] = 8; exp_wa[1] = 9; exp_wa[2] = 10;
    idle();
    pipe_we = 1; pipe_wa = 1; pipe_wd = 32'h1;
    for (int c = 0; c < 3; c++) begin
      lu_valid = 1; lu_wa = exp_wa[c]; lu_wd = {27'd0, exp_wa[c]};
      #4;
      vectors++;
      if ({lu_ready, wa} !== {(c < 2) ? 1'b1 : 1'b0, 5'd1}) begin
        miscompares++;
        $display("FAIL full_fill%0d: rdy/wa=%b/%0d want %b/1", c, lu_ready, wa, (c < 2));
      end
      tick();
    end
    pipe_we = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) lu_valid = 0;
      #4;
      vectors++;
      if ({we, wa, wd} !== {1'b1, exp_wa[c], {27'd0, exp_wa[c]}}) begin
        miscompares++;
        $display("FAIL full_order%0d: we/wa/wd=%b/%0d/%h want 1/%0d", c, we, wa, wd, exp_wa[c]);
      end
      if (c < 2) begin
        vectors++;
        if (lu_ready !== ((c == 1) ? 1'b1 : 1'b0)) begin
          miscompares++;
          $display("FAIL full_ready%0d: got %b want %b", c, lu_ready, (c == 1));
        end
      end
      tick();
    end
    vectors++;
    if (fifo_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL full_cnt: got %0d want 0", fifo_cnt);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1; iss_wa = 12;
    tick();
    idle();
    chk_ra2 = 12;
    #4;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_ra2: got %b want 1", stall);
    end
    chk_ra2 = 0; chk_wa = 12;
    #2;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_wa: got %b want 1", stall);
    end
    lu_valid = 1; lu_wa = 12; lu_wd = 32'hC0C0;
    #2;
    vectors++;
    if ({stall, we, wa} !== {1'b0, 1'b1, 5'd12}) begin
      miscompares++;
      $display("FAIL sb_fwd: stall/we/wa=%b/%b/%0d want 0/1/12", stall, we, wa);
    end
    tick();
    lu_valid = 0;
    #4;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_cleared: got %b want 0", stall);
    end
    // Set and clear of the same register in one cycle: set wins.
    iss_valid = 1; iss_wa = 12;
    tick();
    iss_valid = 0; iss_wa = 12;
    iss_valid = 1;
    lu_valid = 1; lu_wa = 12; lu_wd = 32'h1;
    tick();
    idle();
    chk_ra1 = 12;
    #4;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_set_wins: got %b want 1", stall);
    end
    lu_valid = 1; lu_wa = 12;
    tick();
    idle();
  endtask

  task automatic test_reg0();
    idle();
    iss_valid = 1; iss_wa = 0;
    tick();
    idle();
    lu_valid = 1; lu_wa = 0; lu_wd = 32'hDEAD;
    #4;
    vectors++;
    if ({we, stall, lu_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL r0_lu: we/stall/rdy=%b%b%b want 001", we, stall, lu_ready);
    end
    pipe_we = 1; pipe_wa = 2; pipe_wd = 32'h2;
    tick();
    vectors++;
    if (fifo_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL r0_nopush: got %0d want 0", fifo_cnt);
    end
    lu_wa = 9; lu_wd = 32'h99;
    tick();
    lu_valid = 0;
    pipe_we = 1; pipe_wa = 0; pipe_wd = 32'h5;
    #4;
    vectors++;
    if ({fifo_cnt, we, wa, wd} !== {2'd1, 1'b1, 5'd9, 32'h99}) begin
      miscompares++;
      $display("FAIL r0_pipe_drain: cnt/we/wa/wd=%0d/%b/%0d/%h want 1/1/9/99", fifo_cnt, we, wa, wd);
    end
    tick();
    idle();
    vectors++;
    if (fifo_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL r0_cnt: got %0d want 0", fifo_cnt);
    end
  endtask

  task automatic test_random();
    ent_t        q[$];
    bit [31:0]   mbusy;
    logic        e_we, e_rdy, e_stall, acc, pocc, llw, use_q;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [4:0]  r;
    ent_t        ne;
    idle();
    cpu_rst = 1;
    tick();
    cpu_rst = 0;
    mbusy = 0;
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      pipe_we   = ($urandom_range(0, 1) == 1);
      pipe_wa   = 5'($urandom_range(0, 15));
      pipe_wd   = $urandom;
      lu_valid  = ($urandom_range(0, 9) < 6);
      lu_wa     = 5'($urandom_range(0, 15));
      lu_wd     = $urandom;
      iss_valid = ($urandom_range(0, 9) < 3);
      iss_wa    = 5'($urandom_range(0, 15));
      chk_ra1   = 5'($urandom_range(0, 15));
      chk_ra2   = 5'($urandom_range(0, 15));
      chk_wa    = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        cpu_rst = 1;
        #4;
        vectors++;
        if ({we, lu_ready, stall, fifo_cnt} !== {1'b0, 1'b0, 1'b0, 2'd0}) begin
          miscompares++;
          $display("FAIL rand_reset n=%0d: we/rdy/stall/cnt=%b%b%b/%0d want 000/0", n, we, lu_ready, stall, fifo_cnt);
        end
        tick();
        cpu_rst = 0;
        mbusy = 0;
        q.delete();
        continue;
      end
      pocc  = pipe_we && (pipe_wa != 0);
      e_rdy = (q.size() < DEPTH);
      acc   = lu_valid && e_rdy && (lu_wa != 0);
      use_q = !pocc && (q.size() > 0);
      llw   = 0;
      e_we  = 0; e_wa = 0; e_wd = 0;
      if (pocc) begin
        e_we = 1; e_wa = pipe_wa; e_wd = pipe_wd;
      end else if (use_q) begin
        e_we = 1; e_wa = q[0].wa; e_wd = q[0].wd; llw = 1;
      end else if (acc) begin
        e_we = 1; e_wa = lu_wa; e_wd = lu_wd; llw = 1;
      end
      e_stall = 0;
      for (int k = 0; k < 3; k++) begin
        r = (k == 0) ? chk_ra1 : (k == 1) ? chk_ra2 : chk_wa;
        if (r != 0 && mbusy[r] && !(llw && e_wa == r)) e_stall = 1;
      end
      #4;
      vectors++;
      if ({we, wa, wd, lu_ready, stall} !== {e_we, e_wa, e_wd, e_rdy, e_stall}) begin
        miscompares++;
        $display("FAIL rand_out n=%0d: we/wa/wd/rdy/stall=%b/%0d/%h/%b/%b want %b/%0d/%h/%b/%b",
                 n, we, wa, wd, lu_ready, stall, e_we, e_wa, e_wd, e_rdy, e_stall);
      end
      if (llw) mbusy[e_wa] = 0;
      if (iss_valid && iss_wa != 0) mbusy[iss_wa] = 1;
      if (use_q) void'(q.pop_front());
      if (acc && (pocc || use_q)) begin
        ne.wa = lu_wa; ne.wd = lu_wd;
        q.push_back(ne);
      end
      tick();
      vectors++;
      if (int'(fifo_cnt) != q.size()) begin
        miscompares++;
        $display("FAIL rand_cnt n=%0d: got %0d want %0d", n, fifo_cnt, q.size());
      end
    end
    idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cpu_rst = 1;
    idle();
    test_reset();
    test_bypass();
    test_conflict();
    test_full_order();
    test_scoreboard();
    test_reg0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
